// File: rtl/intctl7.sv
// Seven-line edge-triggered interrupt controller with mask, pending and in-service tracking.
// Define INTCTL7_NEST_EN to allow higher-priority lines to preempt an in-service line.
module intctl7 (
  input  logic       c,
  input  logic       r,
  input  logic [7:1] a,
  input  logic [7:1] m,
  input  logic       mw,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] y,
  output logic [7:1] pend,
  output logic [7:1] isr
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t     state_reg, state_next;
  logic [7:1] a_q_reg, mask_reg, pend_reg, isr_reg;
  logic [7:1] pend_next, isr_next;
  logic [2:0] y_reg, y_next;
  logic       irq_reg;

  logic [7:1] rise, elig, clr, y_onehot, isr_low_onehot;
  logic [2:0] best, isr_low;

  // Lowest-numbered set line wins; 0 means none set.
  function automatic logic [2:0] lowest(input logic [7:1] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  for (genvar gi = 1; gi <= 7; gi++) begin : g_dec
    assign y_onehot[gi]       = (y_reg == 3'(gi));
    assign isr_low_onehot[gi] = (isr_low == 3'(gi));
  end

  assign rise    = a & ~a_q_reg;
  assign elig    = pend_reg & ~mask_reg;
  assign best    = lowest(elig);
  assign isr_low = lowest(isr_reg);

  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    clr        = '0;
    isr_next   = isr_reg;
    case (state_reg)
      IDLE: begin
        if (elig != '0) begin
          state_next = REQ;
          y_next     = best;
        end
      end
      REQ: begin
        if (ack) begin
          clr        = y_onehot;
          isr_next   = isr_reg | y_onehot;
          state_next = SERV;
          y_next     = 3'd0;
        end else begin
`ifdef INTCTL7_NEST_EN
          if (eoi) isr_next = isr_reg & ~isr_low_onehot;
`endif
          if (elig == '0) begin
            y_next = 3'd0;
`ifdef INTCTL7_NEST_EN
            // A preempted line is still in service, so fall back to waiting for its eoi.
            state_next = (isr_next != '0) ? SERV : IDLE;
`else
            state_next = IDLE;
`endif
          end else begin
            y_next = best;
          end
        end
      end
      SERV: begin
        if (eoi) begin
          isr_next = isr_reg & ~isr_low_onehot;
          if (isr_next == '0) state_next = IDLE;
        end
`ifdef INTCTL7_NEST_EN
        else if (best != 3'd0 && best < isr_low) begin
          state_next = REQ;
          y_next     = best;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        y_next     = 3'd0;
      end
    endcase
    // A fresh edge on the line being acknowledged keeps it pending.
    pend_next = (pend_reg & ~clr) | rise;
  end

  always_ff @(posedge c) begin
    if (!r) begin
      state_reg <= IDLE;
      y_reg     <= 3'd0;
      irq_reg   <= 1'b0;
      pend_reg  <= '0;
      isr_reg   <= '0;
      mask_reg  <= 7'h7F;
      a_q_reg   <= a;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      irq_reg   <= (state_next == REQ);
      pend_reg  <= pend_next;
      isr_reg   <= isr_next;
      a_q_reg   <= a;
      if (mw) mask_reg <= m;
    end
  end

  assign irq  = irq_reg;
  assign y    = y_reg;
  assign pend = pend_reg;
  assign isr  = isr_reg;

endmodule

// File: tb/tb_intctl7.sv
// Scoreboard bench for intctl7: directed scenarios then random traffic against a line-level model.
module tb_intctl7;

  logic       c = 1'b0;
  logic       r = 1'b0;
  logic [7:1] a = '0;
  logic [7:1] m = '0;
  logic       mw = 1'b0;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;
  logic       irq;
  logic [2:0] y;
  logic [7:1] pend;
  logic [7:1] isr;

  always #5 c = ~c;

  intctl7 dut (
    .c(c), .r(r), .a(a), .m(m), .mw(mw), .ack(ack), .eoi(eoi),
    .irq(irq), .y(y), .pend(pend), .isr(isr)
  );

  typedef struct packed {
    logic       irq;
    logic [2:0] y;
    logic [7:1] pend;
    logic [7:1] isr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: per-line flags plus a phase (0 waiting, 1 presenting, 2 servicing).
  int ph = 0;
  int pres = 0;
  bit pnd[8];
  bit msk[8];
  bit hist[8];
  bit svc[8];

  function automatic int top_eligible();
    for (int i = 1; i <= 7; i++) if (pnd[i] && !msk[i]) return i;
    return 0;
  endfunction

  function automatic int top_service();
    for (int i = 1; i <= 7; i++) if (svc[i]) return i;
    return 0;
  endfunction

  function automatic bit any_service();
    return top_service() != 0;
  endfunction

  task automatic model_step(input logic rst_n, input logic [7:1] av, input logic [7:1] mv,
                            input logic mwv, input logic ackv, input logic eoiv,
                            output int took, output int retired);
    int cand, low, nph, npres;
    took = 0;
    retired = 0;
    if (!rst_n) begin
      ph = 0;
      pres = 0;
      for (int i = 1; i <= 7; i++) begin
        pnd[i] = 0; svc[i] = 0; msk[i] = 1; hist[i] = av[i];
      end
      return;
    end
    cand = top_eligible();
    low = top_service();
    nph = ph;
    npres = pres;
    case (ph)
      0: if (cand != 0) begin nph = 1; npres = cand; end
      1: begin
        if (ackv) begin
          took = pres;
          svc[pres] = 1;
          nph = 2;
          npres = 0;
        end else begin
`ifdef INTCTL7_NEST_EN
          if (eoiv && low != 0) begin svc[low] = 0; retired = low; end
`endif
          if (cand == 0) begin
            npres = 0;
`ifdef INTCTL7_NEST_EN
            nph = any_service() ? 2 : 0;
`else
            nph = 0;
`endif
          end else begin
            npres = cand;
          end
        end
      end
      default: begin
        if (eoiv) begin
          if (low != 0) begin svc[low] = 0; retired = low; end
          if (!any_service()) nph = 0;
        end
`ifdef INTCTL7_NEST_EN
        else if (cand != 0 && cand < low) begin nph = 1; npres = cand; end
`endif
      end
    endcase
    if (took != 0) pnd[took] = 0;
    for (int i = 1; i <= 7; i++) begin
      if (av[i] && !hist[i]) pnd[i] = 1;
      hist[i] = av[i];
      if (mwv) msk[i] = mv[i];
    end
    ph = nph;
    pres = npres;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.irq = (ph == 1);
    e.y = 3'(pres);
    for (int i = 1; i <= 7; i++) begin
      e.pend[i] = pnd[i];
      e.isr[i] = svc[i];
    end
    return e;
  endfunction

  function automatic logic [7:1] ln(input int n);
    logic [7:1] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic cyc(input logic rst_n, input logic [7:1] av, input logic [7:1] mv,
                     input logic mwv, input logic ackv, input logic eoiv);
    int took, retired;
    r = rst_n; a = av; m = mv; mw = mwv; ack = ackv; eoi = eoiv;
    model_step(rst_n, av, mv, mwv, ackv, eoiv, took, retired);
    sb.push_back(model_out());
    if (took != 0) $display("txn t=%0t ack line %0d", $time, took);
    if (retired != 0) $display("txn t=%0t eoi retires line %0d", $time, retired);
    @(posedge c);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge c);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({irq, y, pend, isr} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got irq=%0b y=%0d pend=%b isr=%b, want irq=%0b y=%0d pend=%b isr=%b",
                   $time, irq, y, pend, isr, e.irq, e.y, e.pend, e.isr);
        end
      end
    end
  end

  logic [7:1] a_rand, flip, mv;
  logic       rst_n, mwv, ackv, eoiv;

  initial begin
    // Reset with all lines held high, then unmask everything.
    cyc(0, 7'h7F, 7'h00, 0, 0, 0);
    cyc(0, 7'h7F, 7'h00, 0, 0, 0);
    check("reset_irq", irq, 0);
    check("reset_isr", isr, 0);
    cyc(1, 7'h7F, 7'h00, 1, 0, 0);
    repeat (10) cyc(1, 7'h7F, 7'h00, 0, 0, 0);
    check("held_lines_no_irq", irq, 0);
    check("held_lines_no_pend", pend, 0);
    repeat (2) cyc(1, 7'h00, 7'h00, 0, 0, 0);

    // Single request on line 5.
    cyc(1, ln(5), 7'h00, 0, 0, 0);
    check("l5_pend", pend, ln(5));
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
    check("l5_irq", irq, 1);
    check("l5_y", y, 5);
    cyc(1, 7'h00, 7'h00, 0, 1, 0);
    check("l5_ack_isr", isr, 7'b0010000);
    check("l5_ack_pend", pend, 0);
    check("l5_ack_irq", irq, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);
    check("l5_eoi_isr", isr, 0);

    // Simultaneous edges on lines 6 and 3.
    cyc(1, ln(6) | ln(3), 7'h00, 0, 0, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
    check("pri_y3", y, 3);
    cyc(1, 7'h00, 7'h00, 0, 1, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
    check("pri_y6", y, 6);
    cyc(1, 7'h00, 7'h00, 0, 1, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);

    // Masked line 3 becomes visible after unmasking.
    cyc(1, 7'h00, ln(3), 1, 0, 0);
    cyc(1, ln(3), 7'h00, 0, 0, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
    check("mask_pend3", pend[3], 1);
    check("mask_no_irq", irq, 0);
    cyc(1, 7'h00, 7'h00, 1, 0, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
    check("unmask_irq", irq, 1);
    check("unmask_y", y, 3);
    cyc(1, 7'h00, 7'h00, 0, 1, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);

    // Line 2 arrives while line 6 is in service.
    cyc(1, ln(6), 7'h00, 0, 0, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
    cyc(1, 7'h00, 7'h00, 0, 1, 0);
    cyc(1, ln(2), 7'h00, 0, 0, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
`ifdef INTCTL7_NEST_EN
    check("nest_irq", irq, 1);
    check("nest_y", y, 2);
    cyc(1, 7'h00, 7'h00, 0, 1, 0);
    check("nest_isr2", isr, 7'b0100010);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);
    check("nest_isr1", isr, 7'b0100000);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);
`else
    repeat (3) cyc(1, 7'h00, 7'h00, 0, 0, 0);
    check("nonest_no_irq", irq, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
    check("nonest_y2", y, 2);
    cyc(1, 7'h00, 7'h00, 0, 1, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);
`endif

    // Ack on line 4 coinciding with a fresh edge on line 4.
    cyc(1, ln(4), 7'h00, 0, 0, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
    check("same_y4", y, 4);
    cyc(1, ln(4), 7'h00, 0, 1, 0);
    check("same_pend4", pend[4], 1);
    check("same_isr4", isr[4], 1);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);
    cyc(1, 7'h00, 7'h00, 0, 0, 0);
    check("same_rerequest_y4", y, 4);
    cyc(1, 7'h00, 7'h00, 0, 1, 0);
    cyc(1, 7'h00, 7'h00, 0, 0, 1);

    // Random traffic.
    a_rand = '0;
    for (int k = 0; k < 3000; k++) begin
      flip = '0;
      for (int i = 1; i <= 7; i++) if ($urandom_range(0, 9) == 0) flip[i] = 1'b1;
      a_rand = a_rand ^ flip;
      rst_n = ($urandom_range(0, 399) != 0);
      mwv = ($urandom_range(0, 15) == 0);
      mv = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      ackv = ($urandom_range(0, 2) == 0);
      eoiv = ($urandom_range(0, 3) == 0);
      cyc(rst_n, a_rand, mv, mwv, ackv, eoiv);
    end

    @(posedge c);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
